tl_ram_responder: RTL and testbench



---
 rtl/tl_ram_responder.sv | 165 ++++++++++++++++
 tb/tb_tl_ram_responder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ram_responder.sv
// TileLink-UL RAM slave: single response slot in front of a small 64-bit register file.
// Optional error counter port io_err_count is enabled by defining TL_RESPONDER_ERR_COUNT_EN.
module tl_ram_responder #(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int          WORDS_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic [2:0]  io_a_bits_param,
  input  logic [3:0]  io_a_bits_size,
  input  logic [1:0]  io_a_bits_source,
  input  logic [31:0] io_a_bits_address,
  input  logic [7:0]  io_a_bits_mask,
  input  logic [63:0] io_a_bits_data,
  input  logic        io_a_bits_corrupt,
  output logic        io_d_valid,
  input  logic        io_d_ready,
  output logic [2:0]  io_d_bits_opcode,
  output logic [1:0]  io_d_bits_param,
  output logic [3:0]  io_d_bits_size,
  output logic [1:0]  io_d_bits_source,
  output logic        io_d_bits_sink,
  output logic        io_d_bits_denied,
  output logic        io_d_bits_corrupt,
  output logic [63:0] io_d_bits_data
`ifdef TL_RESPONDER_ERR_COUNT_EN
  ,
  output logic [15:0] io_err_count
`endif
);

  localparam int WORDS = 1 << WORDS_LOG2;

  logic [63:0]           mem [WORDS];
  logic [WORDS-1:0]      poison;

  logic                  d_valid;
  logic [2:0]            d_opcode;
  logic [3:0]            d_size;
  logic [1:0]            d_source;
  logic                  d_denied;
  logic                  d_corrupt;
  logic [63:0]           d_data;

  logic                  accept;
  logic [WORDS_LOG2-1:0] word_idx;
  logic                  in_window;
  logic                  aligned;
  logic                  legal;
  logic                  is_get;
  logic                  is_put;
  logic                  data_opcode;
  logic                  do_write;
  logic                  nxt_denied;
  logic                  nxt_corrupt;
  logic [63:0]           nxt_data;

  // param carries no meaning for this slave
  logic                  unused_param;
  assign unused_param = ^io_a_bits_param;

  assign io_a_ready = ~d_valid | io_d_ready;
  assign accept     = io_a_valid & io_a_ready;
  assign word_idx   = io_a_bits_address[WORDS_LOG2+2:3];
  assign in_window  = io_a_bits_address[31:WORDS_LOG2+3] == BASE[31:WORDS_LOG2+3];

  always_comb begin
    case (io_a_bits_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = ~io_a_bits_address[0];
      4'd2:    aligned = io_a_bits_address[1:0] == 2'b00;
      4'd3:    aligned = io_a_bits_address[2:0] == 3'b000;
      default: aligned = 1'b0;
    endcase
  end

  assign legal  = in_window & (io_a_bits_size <= 4'd3) & aligned;
  assign is_get = io_a_bits_opcode == 3'd4;
  assign is_put = (io_a_bits_opcode == 3'd0) | (io_a_bits_opcode == 3'd1);

  // Get and the reserved opcodes 2/3 always answer with AccessAckData, even when denied
  assign data_opcode = is_get | (io_a_bits_opcode == 3'd2) | (io_a_bits_opcode == 3'd3);
  assign nxt_denied  = ~(legal & (is_get | is_put));
  assign do_write    = accept & legal & is_put;

  always_comb begin
    nxt_corrupt = 1'b0;
    nxt_data    = 64'd0;
    if (nxt_denied) begin
      nxt_corrupt = data_opcode;
    end else if (is_get) begin
      nxt_corrupt = poison[word_idx];
      nxt_data    = mem[word_idx];
    end
  end

  // Storage commits on the accept edge, so a following Get sees the new bytes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 64'd0;
      end
      poison <= '0;
    end else if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (io_a_bits_mask[b]) begin
          mem[word_idx][8*b +: 8] <= io_a_bits_data[8*b +: 8];
        end
      end
      if (|io_a_bits_mask) begin
        poison[word_idx] <= io_a_bits_corrupt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= 2'd0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= 64'd0;
    end else if (accept) begin
      d_valid   <= 1'b1;
      d_opcode  <= {2'b00, data_opcode};
      d_size    <= io_a_bits_size;
      d_source  <= io_a_bits_source;
      d_denied  <= nxt_denied;
      d_corrupt <= nxt_corrupt;
      d_data    <= nxt_data;
    end else if (io_d_ready) begin
      d_valid   <= 1'b0;
    end
  end

`ifdef TL_RESPONDER_ERR_COUNT_EN
  logic [15:0] err_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= 16'd0;
    end else if (accept && nxt_denied && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign io_err_count = err_count;
`endif

  assign io_d_valid        = d_valid;
  assign io_d_bits_opcode  = d_opcode;
  assign io_d_bits_param   = 2'd0;
  assign io_d_bits_size    = d_size;
  assign io_d_bits_source  = d_source;
  assign io_d_bits_sink    = 1'b0;
  assign io_d_bits_denied  = d_denied;
  assign io_d_bits_corrupt = d_corrupt;
  assign io_d_bits_data    = d_data;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Bench for tl_ram_responder: behavioural TileLink RAM model, per-cycle compare process,
// directed literal checks and a randomized stream. Honours TL_RESPONDER_ERR_COUNT_EN.
module tb_tl_ram_responder;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          WINDOW = 128;

  logic        clock;
  logic        reset;
  logic        io_a_valid;
  logic        io_a_ready;
  logic [2:0]  io_a_bits_opcode;
  logic [2:0]  io_a_bits_param;
  logic [3:0]  io_a_bits_size;
  logic [1:0]  io_a_bits_source;
  logic [31:0] io_a_bits_address;
  logic [7:0]  io_a_bits_mask;
  logic [63:0] io_a_bits_data;
  logic        io_a_bits_corrupt;
  logic        io_d_valid;
  logic        io_d_ready;
  logic [2:0]  io_d_bits_opcode;
  logic [1:0]  io_d_bits_param;
  logic [3:0]  io_d_bits_size;
  logic [1:0]  io_d_bits_source;
  logic        io_d_bits_sink;
  logic        io_d_bits_denied;
  logic        io_d_bits_corrupt;
  logic [63:0] io_d_bits_data;
`ifdef TL_RESPONDER_ERR_COUNT_EN
  logic [15:0] io_err_count;
`endif

  tl_ram_responder #(.BASE(BASE), .WORDS_LOG2(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_a_valid        (io_a_valid),
    .io_a_ready        (io_a_ready),
    .io_a_bits_opcode  (io_a_bits_opcode),
    .io_a_bits_param   (io_a_bits_param),
    .io_a_bits_size    (io_a_bits_size),
    .io_a_bits_source  (io_a_bits_source),
    .io_a_bits_address (io_a_bits_address),
    .io_a_bits_mask    (io_a_bits_mask),
    .io_a_bits_data    (io_a_bits_data),
    .io_a_bits_corrupt (io_a_bits_corrupt),
    .io_d_valid        (io_d_valid),
    .io_d_ready        (io_d_ready),
    .io_d_bits_opcode  (io_d_bits_opcode),
    .io_d_bits_param   (io_d_bits_param),
    .io_d_bits_size    (io_d_bits_size),
    .io_d_bits_source  (io_d_bits_source),
    .io_d_bits_sink    (io_d_bits_sink),
    .io_d_bits_denied  (io_d_bits_denied),
    .io_d_bits_corrupt (io_d_bits_corrupt),
    .io_d_bits_data    (io_d_bits_data)
`ifdef TL_RESPONDER_ERR_COUNT_EN
    ,
    .io_err_count      (io_err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [1:0]  src;
    logic        den;
    logic        cor;
    logic [63:0] data;
  } rsp_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        cor;
  } req_t;

  int total = 0;
  int bad   = 0;

  rsp_t        exp_q [$];
  req_t        req_q [$];
  logic [63:0] m_mem [16];
  logic        m_pois [16];
  int          m_err;

  logic [2:0]  got_op;
  logic [1:0]  got_src;
  logic        got_valid;
  logic        got_den;
  logic        got_cor;
  logic [63:0] got_data;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: TileLink RAM semantics in terms of byte addresses and a word array
  function automatic rsp_t model_access(input req_t q);
    rsp_t r;
    bit   legal;
    int   w;
    legal = (q.addr >= BASE) && (q.addr < BASE + WINDOW) && (q.size <= 4'd3);
    if (legal) legal = (q.addr % (32'd1 << q.size)) == 0;
    w = int'((q.addr - BASE) / 8);
    r.size = q.size;
    r.src  = q.src;
    r.data = 64'd0;
    r.den  = 1'b0;
    r.cor  = 1'b0;
    if (legal && q.op == 3'd4) begin
      r.op   = 3'd1;
      r.data = m_mem[w];
      r.cor  = m_pois[w];
    end else if (legal && (q.op == 3'd0 || q.op == 3'd1)) begin
      r.op = 3'd0;
      for (int b = 0; b < 8; b++) begin
        if (q.mask[b]) m_mem[w][8*b +: 8] = q.data[8*b +: 8];
      end
      if (q.mask != 8'd0) m_pois[w] = q.cor;
    end else begin
      r.den = 1'b1;
      if (q.op == 3'd4 || q.op == 3'd2 || q.op == 3'd3) begin
        r.op  = 3'd1;
        r.cor = 1'b1;
      end else begin
        r.op = 3'd0;
      end
      if (m_err < 65535) m_err++;
    end
    return r;
  endfunction

  // Compare process: every falling edge, check the D slot and err counter, then log any
  // handshake that will complete on the coming rising edge
  always @(negedge clock) begin
    req_t cur;
    if (!reset) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        m_mem[i]  = 64'd0;
        m_pois[i] = 1'b0;
      end
      m_err = 0;
    end else begin
      check_output("d_valid", io_d_valid, exp_q.size() != 0);
      check_output("a_ready", io_a_ready, (exp_q.size() == 0) || io_d_ready);
      if (io_d_valid && exp_q.size() > 0) begin
        check_output("d_opcode", io_d_bits_opcode, exp_q[0].op);
        check_output("d_data", io_d_bits_data, exp_q[0].data);
        check_output("d_denied", io_d_bits_denied, exp_q[0].den);
        check_output("d_corrupt", io_d_bits_corrupt, exp_q[0].cor);
        check_output("d_source", io_d_bits_source, exp_q[0].src);
        check_output("d_size", io_d_bits_size, exp_q[0].size);
        check_output("d_param_sink", {io_d_bits_param, io_d_bits_sink}, 3'd0);
        if (io_d_ready) void'(exp_q.pop_front());
      end
`ifdef TL_RESPONDER_ERR_COUNT_EN
      check_output("err_count", io_err_count, m_err);
`endif
      if (io_a_valid && io_a_ready) begin
        cur.op   = io_a_bits_opcode;
        cur.size = io_a_bits_size;
        cur.src  = io_a_bits_source;
        cur.addr = io_a_bits_address;
        cur.mask = io_a_bits_mask;
        cur.data = io_a_bits_data;
        cur.cor  = io_a_bits_corrupt;
        exp_q.push_back(model_access(cur));
      end
    end
  end

  task automatic drive_req(input req_t q);
    io_a_bits_opcode  = q.op;
    io_a_bits_param   = 3'($urandom_range(7));
    io_a_bits_size    = q.size;
    io_a_bits_source  = q.src;
    io_a_bits_address = q.addr;
    io_a_bits_mask    = q.mask;
    io_a_bits_data    = q.data;
    io_a_bits_corrupt = q.cor;
  endtask

  // One request with io_d_ready high; captures the response seen one cycle after accept
  task automatic apply_stimulus(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                                input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
    req_t q;
    int   n;
    q.op = op; q.size = size; q.src = src; q.addr = addr; q.mask = mask; q.data = data; q.cor = 1'b0;
    @(posedge clock); #1;
    drive_req(q);
    io_a_valid = 1'b1;
    io_d_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!io_a_ready && n < 50);
    if (n >= 50) check_output("accept_timeout", 1'b0, 1'b1);
    @(posedge clock); #1;
    io_a_valid = 1'b0;
    @(negedge clock);
    got_valid = io_d_valid;
    got_op    = io_d_bits_opcode;
    got_src   = io_d_bits_source;
    got_den   = io_d_bits_denied;
    got_cor   = io_d_bits_corrupt;
    got_data  = io_d_bits_data;
  endtask

  function automatic req_t random_req();
    req_t q;
    int   r;
    int   off;
    r = $urandom_range(9);
    if (r < 3)      q.op = 3'd4;
    else if (r < 5) q.op = 3'd0;
    else if (r < 7) q.op = 3'd1;
    else            q.op = 3'($urandom_range(7));
    q.size = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
    if ($urandom_range(9) == 0) begin
      q.addr = $urandom();
    end else begin
      off = $urandom_range(WINDOW - 1);
      if (q.size <= 4'd3 && $urandom_range(3) != 0) off = off - (off % (1 << q.size));
      q.addr = BASE + 32'(off);
    end
    q.mask = 8'($urandom());
    q.data = {$urandom(), $urandom()};
    q.cor  = ($urandom_range(3) == 0);
    return q;
  endfunction

  // Streams everything in req_q; hold_low forces io_d_ready low for the first cycles
  task automatic run_stream(input int n, input int ready_pct, input int hold_low, input int gap_pct,
                            output int cycles);
    int  sent;
    int  cyc;
    int  w;
    bit  fired;
    sent  = 0;
    cyc   = 0;
    fired = 0;
    while (sent < n && cyc < 5000) begin
      @(posedge clock); #1;
      if (fired) begin
        io_a_valid = 1'b0;
        fired      = 0;
      end
      io_d_ready = (cyc < hold_low) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (!io_a_valid && req_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        drive_req(req_q.pop_front());
        io_a_valid = 1'b1;
      end
      @(negedge clock);
      if (hold_low > 0 && (cyc == 1 || cyc == 2)) check_output("bp_a_ready_low", io_a_ready, 1'b0);
      if (io_a_valid && io_a_ready) begin
        fired = 1;
        sent++;
      end
      cyc++;
    end
    check_output("stream_sent", sent, n);
    @(posedge clock); #1;
    io_a_valid = 1'b0;
    io_d_ready = 1'b1;
    w = 0;
    while (io_d_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    check_output("stream_drained", io_d_valid, 1'b0);
    cycles = cyc;
  endtask

  initial begin
    req_t q;
    int   cyc;
    reset             = 1'b0;
    io_a_valid        = 1'b0;
    io_d_ready        = 1'b1;
    io_a_bits_opcode  = 3'd0;
    io_a_bits_param   = 3'd0;
    io_a_bits_size    = 4'd0;
    io_a_bits_source  = 2'd0;
    io_a_bits_address = 32'd0;
    io_a_bits_mask    = 8'd0;
    io_a_bits_data    = 64'd0;
    io_a_bits_corrupt = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    @(negedge clock);
    check_output("rst_d_valid", io_d_valid, 1'b0);
    check_output("rst_a_ready", io_a_ready, 1'b1);
    check_output("rst_d_bits", {io_d_bits_opcode, io_d_bits_denied, io_d_bits_corrupt, io_d_bits_size}, 9'd0);
    check_output("rst_d_data", io_d_bits_data, 64'd0);
`ifdef TL_RESPONDER_ERR_COUNT_EN
    check_output("rst_err_count", io_err_count, 16'd0);
`endif

    apply_stimulus(3'd0, 4'd3, 2'd1, 32'h1008, 8'hFF, 64'h1122334455667788);
    check_output("put_valid", got_valid, 1'b1);
    check_output("put_op", got_op, 3'd0);
    check_output("put_src", got_src, 2'd1);
    check_output("put_den_cor", {got_den, got_cor}, 2'b00);

    apply_stimulus(3'd4, 4'd3, 2'd2, 32'h1008, 8'h00, 64'd0);
    check_output("get_op", got_op, 3'd1);
    check_output("get_data", got_data, 64'h1122334455667788);
    check_output("get_src", got_src, 2'd2);
    check_output("get_den_cor", {got_den, got_cor}, 2'b00);

    apply_stimulus(3'd1, 4'd3, 2'd3, 32'h1008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
    check_output("pput_op", got_op, 3'd0);
    apply_stimulus(3'd4, 4'd3, 2'd0, 32'h1008, 8'hFF, 64'd0);
    check_output("pget_data", got_data, 64'h11223344BBBBBBBB);

    apply_stimulus(3'd4, 4'd3, 2'd1, 32'h2000, 8'hFF, 64'd0);
    check_output("oow_op", got_op, 3'd1);
    check_output("oow_den_cor", {got_den, got_cor}, 2'b11);
    check_output("oow_data", got_data, 64'd0);
`ifdef TL_RESPONDER_ERR_COUNT_EN
    check_output("oow_err_count", io_err_count, 16'd1);
`endif

    apply_stimulus(3'd0, 4'd2, 2'd0, 32'h1002, 8'h0C, 64'hDEAD_BEEF_DEAD_BEEF);
    check_output("misalign_op", got_op, 3'd0);
    check_output("misalign_den_cor", {got_den, got_cor}, 2'b10);
    apply_stimulus(3'd4, 4'd4, 2'd0, 32'h1000, 8'hFF, 64'd0);
    check_output("oversize_den", got_den, 1'b1);
    apply_stimulus(3'd4, 4'd3, 2'd0, 32'h1008, 8'hFF, 64'd0);
    check_output("untouched_data", got_data, 64'h11223344BBBBBBBB);

    // Four back-to-back Gets against a stalled D channel
    for (int i = 0; i < 4; i++) begin
      q.op = 3'd4; q.size = 4'd3; q.src = 2'(i); q.addr = BASE + 32'(8 * i);
      q.mask = 8'hFF; q.data = 64'd0; q.cor = 1'b0;
      req_q.push_back(q);
    end
    run_stream(4, 100, 3, 0, cyc);

    for (int i = 0; i < 8; i++) begin
      q = random_req();
      req_q.push_back(q);
    end
    run_stream(8, 100, 0, 0, cyc);
    check_output("throughput_cycles", cyc, 8);

    for (int i = 0; i < 300; i++) begin
      q = random_req();
      req_q.push_back(q);
    end
    run_stream(300, 60, 0, 30, cyc);

    // Reset while a response is held in the slot
    apply_stimulus(3'd0, 4'd3, 2'd0, 32'h1010, 8'hFF, 64'hCAFE_F00D_1234_5678);
    @(posedge clock); #1;
    io_d_ready = 1'b0;
    q.op = 3'd4; q.size = 4'd3; q.src = 2'd1; q.addr = 32'h1010; q.mask = 8'hFF; q.data = 64'd0; q.cor = 1'b0;
    drive_req(q);
    io_a_valid = 1'b1;
    @(posedge clock); #1;
    io_a_valid = 1'b0;
    #2;
    check_output("pre_reset_valid", io_d_valid, 1'b1);
    reset = 1'b0;
    #1;
    check_output("async_reset_valid", io_d_valid, 1'b0);
    check_output("async_reset_a_ready", io_a_ready, 1'b1);
    @(posedge clock); #1;
    reset      = 1'b1;
    io_d_ready = 1'b1;
    apply_stimulus(3'd4, 4'd3, 2'd2, 32'h1010, 8'hFF, 64'd0);
    check_output("post_reset_data", got_data, 64'd0);
    check_output("post_reset_op", got_op, 3'd1);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
